// File: rtl/dmem_mmio_responder_pkg.sv
// dmem_pkg: shared constants and types for the data-memory / MMIO responder.
//   - MMIO word offsets inside the 256-byte window
//   - STATUS register bit indices
//   - OOR_PATTERN, returned for trapped out-of-range RAM reads
//   - cons_status_t, the {full, empty} pair read back from CONSOLE
package dmem_pkg;

  localparam logic [7:0] OFF_CONSOLE = 8'h00;
  localparam logic [7:0] OFF_CYCLE   = 8'h04;
  localparam logic [7:0] OFF_HALT    = 8'h08;
  localparam logic [7:0] OFF_STATUS  = 8'h0C;

  localparam int ST_OVERFLOW = 0;
  localparam int ST_OOR      = 1;

  localparam logic [31:0] OOR_PATTERN = 32'hDEAD_BEEF;

  typedef struct packed {
    logic full;
    logic empty;
  } cons_status_t;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Data-memory bus between the core (master) and the responder (slave).
//   memwrite  : write strobe, sampled at posedge clk
//   aluout    : byte address, bits [1:0] ignored
//   writedata : write data
//   readdata  : read data, combinational from aluout and responder state
// There is no handshake: every access completes in the cycle it is presented.
interface dmem_mmio_responder_if;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output memwrite, output aluout, output writedata, input readdata);
  modport slave  (input memwrite, input aluout, input writedata, output readdata);
endinterface

// File: rtl/dmem_mmio_responder_console_fifo.sv
// console_fifo: synchronous FIFO for the console TX path.
//   clk, reset      : clock, asynchronous active-low reset (flushes contents)
//   push, din       : write side; a push is taken if not full or if a pop
//                     happens in the same cycle
//   full, empty     : occupancy flags
//   drop            : push refused this cycle (FIFO full, no pop)
//   valid, ready    : drain handshake; a byte moves when valid && ready.
//                     valid stays high and dout stays constant until ready.
//   dout            : head byte, read from registered storage
module console_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic             drop,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] dout
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             pop;
  logic             accept;

  assign full   = (count == (PW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign valid  = !empty;
  assign pop    = valid && ready;
  // When full, a simultaneous pop frees the head slot, which is exactly the
  // slot wr_ptr points at, so the new byte lands behind all older ones.
  assign accept = push && (!full || pop);
  assign drop   = push && !accept;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: data-memory responder beside the core.
// Holds a word RAM plus a 256-byte MMIO window at MMIO_BASE:
//   0x00 CONSOLE  read {30'b0, full, empty}; write pushes writedata[7:0]
//   0x04 CYCLE    free-running counter, frozen while halted, loadable
//   0x08 HALT     first write latches halt_code and sets halt
//   0x0C STATUS   bit0 overflow, bit1 oor; write-1-to-clear, set wins
// Ports:
//   clk, reset          : clock, asynchronous active-low reset
//   bus (slave)         : memwrite / aluout / writedata in, readdata out
//   cons_data/valid     : console byte stream out, ready from the sink
//   halt, halt_code     : sticky halt flag and its code
// Build option DMEM_OOR_TRAP_EN: RAM addresses >= DEPTH_WORDS*4 read
// OOR_PATTERN, drop writes and set STATUS.oor instead of aliasing.
module dmem_mmio_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dmem_mmio_responder_if.slave  bus,
  output logic [7:0]            cons_data,
  output logic                  cons_valid,
  input  logic                  cons_ready,
  output logic                  halt,
  output logic [31:0]           halt_code
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [AW-1:0] ram_idx;
  logic          is_mmio;
  logic          oor;
  logic          ram_we;
  logic          sel_console, sel_cycle, sel_halt, sel_status;
  logic          fifo_full, fifo_empty, fifo_drop;
  logic [31:0]   cycle_q;
  logic [1:0]    status_q;
  logic [1:0]    status_set;
  logic [1:0]    status_clr;
  cons_status_t  cons_st;
  logic          unused_addr_lsbs;

  // Byte-lane bits are meaningless for whole-word accesses.
  assign unused_addr_lsbs = ^bus.aluout[1:0];

  assign is_mmio = (bus.aluout[31:8] == MMIO_BASE[31:8]);
  assign ram_idx = bus.aluout[AW+1:2];

`ifdef DMEM_OOR_TRAP_EN
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  assign oor = !is_mmio && (bus.aluout >= RAM_BYTES);
`else
  assign oor = 1'b0;
`endif

  assign sel_console = is_mmio && (bus.aluout[7:2] == OFF_CONSOLE[7:2]);
  assign sel_cycle   = is_mmio && (bus.aluout[7:2] == OFF_CYCLE[7:2]);
  assign sel_halt    = is_mmio && (bus.aluout[7:2] == OFF_HALT[7:2]);
  assign sel_status  = is_mmio && (bus.aluout[7:2] == OFF_STATUS[7:2]);

  assign ram_we = bus.memwrite && !is_mmio && !oor;

  assign cons_st.full  = fifo_full;
  assign cons_st.empty = fifo_empty;

  console_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.memwrite && sel_console),
    .din   (bus.writedata[7:0]),
    .full  (fifo_full),
    .empty (fifo_empty),
    .drop  (fifo_drop),
    .valid (cons_valid),
    .ready (cons_ready),
    .dout  (cons_data)
  );

  // RAM has no reset; a write presented while reset is low is discarded.
  always_ff @(posedge clk) begin
    if (reset && ram_we) ram[ram_idx] <= bus.writedata;
  end

  always_comb begin
    bus.readdata = 32'h0;
    if (is_mmio) begin
      if (sel_console)     bus.readdata = {30'b0, cons_st};
      else if (sel_cycle)  bus.readdata = cycle_q;
      else if (sel_halt)   bus.readdata = halt_code;
      else if (sel_status) bus.readdata = {30'b0, status_q};
    end else if (oor) begin
      bus.readdata = OOR_PATTERN;
    end else begin
      bus.readdata = ram[ram_idx];
    end
  end

  always_comb begin
    status_set              = 2'b00;
    status_set[ST_OVERFLOW] = fifo_drop;
    // Any trapped RAM-region access flags oor, read or write.
    status_set[ST_OOR]      = oor;
    status_clr              = (bus.memwrite && sel_status) ? bus.writedata[1:0] : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= 32'h0;
      halt      <= 1'b0;
      halt_code <= 32'h0;
      status_q  <= 2'b00;
    end else begin
      if (bus.memwrite && sel_cycle) cycle_q <= bus.writedata;
      else if (!halt)                cycle_q <= cycle_q + 32'h1;

      if (bus.memwrite && sel_halt && !halt) begin
        halt      <= 1'b1;
        halt_code <= bus.writedata;
      end

      status_q <= (status_q & ~status_clr) | status_set;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
module tb_dmem_mmio_responder;
  import dmem_pkg::*;

  localparam int          DEPTH_WORDS = 64;
  localparam logic [31:0] MMIO_BASE   = 32'hFFFF_FF00;
  localparam logic [31:0] A_CONSOLE   = MMIO_BASE + 32'h0;
  localparam logic [31:0] A_CYCLE     = MMIO_BASE + 32'h4;
  localparam logic [31:0] A_HALT      = MMIO_BASE + 32'h8;
  localparam logic [31:0] A_STATUS    = MMIO_BASE + 32'hC;
  localparam logic [31:0] A_IDLE      = 32'h0000_0000;

  logic       clk;
  logic       reset;
  logic [7:0] cons_data;
  logic       cons_valid;
  logic       cons_ready;
  logic       halt;
  logic [31:0] halt_code;

  int checks;
  int failures;
  logic [31:0] ram_exp;
  logic [7:0]  exp_bytes [4];

  dmem_mmio_responder_if bus ();

  dmem_mmio_responder #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .MMIO_BASE   (MMIO_BASE),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready),
    .halt       (halt),
    .halt_code  (halt_code)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.aluout    = addr;
    bus.writedata = data;
    bus.memwrite  = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite  = 1'b0;
    bus.aluout    = A_IDLE;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    bus.memwrite = 1'b0;
    bus.aluout   = addr;
    #1;
    check(tag, bus.readdata, exp);
    bus.aluout   = A_IDLE;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.memwrite  = 1'b0;
    bus.aluout    = A_IDLE;
    bus.writedata = 32'h0;
    cons_ready    = 1'b0;

    // reset state
    tick();
    tick();
    check("rst_cons_valid", {31'b0, cons_valid}, 32'h0);
    check("rst_cons_data", {24'b0, cons_data}, 32'h0);
    check("rst_halt", {31'b0, halt}, 32'h0);
    check("rst_halt_code", halt_code, 32'h0);
    rd(A_CYCLE, 32'h0, "rst_cycle");
    rd(A_STATUS, 32'h0, "rst_status");
    rd(A_CONSOLE, 32'h1, "rst_console_empty");
    rd(MMIO_BASE + 32'h40, 32'h0, "unmapped_mmio");

    // cycle counter from release
    reset = 1'b1;
    repeat (10) tick();
    rd(A_CYCLE, 32'd10, "cycle_10");

    // cycle load and wrap
    wr(A_CYCLE, 32'hFFFF_FFFE);
    rd(A_CYCLE, 32'hFFFF_FFFE, "cycle_load");
    tick();
    rd(A_CYCLE, 32'hFFFF_FFFF, "cycle_max");
    tick();
    rd(A_CYCLE, 32'h0, "cycle_wrap");

    // RAM write/read, read-during-write returns old value
    wr(32'h10, 32'h1234_5678);
    rd(32'h10, 32'h1234_5678, "ram_rd");
    bus.aluout    = 32'h13;
    bus.writedata = 32'hA5A5_0001;
    bus.memwrite  = 1'b1;
    #1;
    check("ram_rd_during_wr", bus.readdata, 32'h1234_5678);
    tick();
    bus.memwrite = 1'b0;
    rd(32'h10, 32'hA5A5_0001, "ram_rd_after_wr");
    ram_exp = 32'hA5A5_0001;

    // RAM alias / out-of-range
    bus.aluout = 32'h10 + DEPTH_WORDS * 4;
    #1;
`ifdef DMEM_OOR_TRAP_EN
    check("oor_rd", bus.readdata, OOR_PATTERN);
`else
    check("alias_rd", bus.readdata, 32'hA5A5_0001);
`endif
    tick();
    bus.aluout = A_IDLE;
`ifdef DMEM_OOR_TRAP_EN
    rd(A_STATUS, 32'h2, "oor_status");
`else
    rd(A_STATUS, 32'h0, "alias_status");
`endif
    wr(A_STATUS, 32'h2);
    rd(A_STATUS, 32'h0, "status_clr_oor");
    wr(32'h10 + DEPTH_WORDS * 4, 32'hCAFE_F00D);
`ifdef DMEM_OOR_TRAP_EN
    rd(32'h10, 32'hA5A5_0001, "oor_wr_dropped");
`else
    ram_exp = 32'hCAFE_F00D;
    rd(32'h10, 32'hCAFE_F00D, "alias_wr");
`endif
    wr(A_STATUS, 32'h2);

    // console overflow
    wr(A_CONSOLE, 32'h41);
    check("cons_first_valid", {31'b0, cons_valid}, 32'h1);
    check("cons_first_data", {24'b0, cons_data}, 32'h41);
    wr(A_CONSOLE, 32'h42);
    wr(A_CONSOLE, 32'h43);
    wr(A_CONSOLE, 32'h44);
    wr(A_CONSOLE, 32'h45);
    rd(A_STATUS, 32'h1, "ovf_status");
    rd(A_CONSOLE, 32'h2, "ovf_console_full");
    check("cons_hold_data", {24'b0, cons_data}, 32'h41);
    exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42;
    exp_bytes[2] = 8'h43; exp_bytes[3] = 8'h44;
    cons_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'b0, cons_valid}, 32'h1);
      check("drain_data", {24'b0, cons_data}, {24'b0, exp_bytes[i]});
      tick();
    end
    check("drain_empty", {31'b0, cons_valid}, 32'h0);
    cons_ready = 1'b0;

    // STATUS write-1-to-clear overflow
    wr(A_STATUS, 32'h1);
    rd(A_STATUS, 32'h0, "status_clr_ovf");

    // push into full FIFO alongside a pop
    wr(A_CONSOLE, 32'h50);
    wr(A_CONSOLE, 32'h51);
    wr(A_CONSOLE, 32'h52);
    wr(A_CONSOLE, 32'h53);
    rd(A_CONSOLE, 32'h2, "full_console");
    cons_ready = 1'b1;
    wr(A_CONSOLE, 32'h5A);
    rd(A_STATUS, 32'h0, "push_pop_no_ovf");
    exp_bytes[0] = 8'h51; exp_bytes[1] = 8'h52;
    exp_bytes[2] = 8'h53; exp_bytes[3] = 8'h5A;
    for (int i = 0; i < 4; i++) begin
      check("pp_valid", {31'b0, cons_valid}, 32'h1);
      check("pp_data", {24'b0, cons_data}, {24'b0, exp_bytes[i]});
      tick();
    end
    check("pp_empty", {31'b0, cons_valid}, 32'h0);
    cons_ready = 1'b0;

    // halt
    wr(A_CYCLE, 32'd100);
    wr(A_HALT, 32'd7);
    wr(A_HALT, 32'd9);
    check("halt_flag", {31'b0, halt}, 32'h1);
    check("halt_code", halt_code, 32'd7);
    rd(A_HALT, 32'd7, "halt_rd");
    rd(A_CYCLE, 32'd101, "cycle_at_halt");
    repeat (5) tick();
    rd(A_CYCLE, 32'd101, "cycle_frozen");

    // async reset mid-drain
    wr(A_CONSOLE, 32'h4D);
    wr(A_CONSOLE, 32'h4E);
    cons_ready = 1'b1;
    tick();
    check("pre_rst_data", {24'b0, cons_data}, 32'h4E);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_valid", {31'b0, cons_valid}, 32'h0);
    check("async_rst_data", {24'b0, cons_data}, 32'h0);
    cons_ready = 1'b0;
    wr(32'h10, 32'h0BAD_0BAD);
    reset = 1'b1;
    check("post_rst_halt", {31'b0, halt}, 32'h0);
    check("post_rst_halt_code", halt_code, 32'h0);
    rd(A_CYCLE, 32'h0, "post_rst_cycle");
    rd(A_CONSOLE, 32'h1, "post_rst_console");
    rd(32'h10, ram_exp, "ram_wr_in_reset_lost");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
Name: dmem_mmio_responder

Overview:
- Responder end of the core's data-memory bus: the core drives memwrite, aluout (address) and writedata; this block returns readdata in the same cycle.
- Contains a word RAM and a small MMIO window:
  - console TX FIFO with a valid/ready drain port
  - free-running cycle counter
  - halt register
  - sticky status register
- Instantiated beside the core in the top-level testbench/SoC wrapper.

Parameters:
- DEPTH_WORDS, 64, RAM depth in 32-bit words; power of two.
- MMIO_BASE, 32'hFFFF_FF00, base of the 256-byte MMIO window; the low 8 bits must be zero.
- FIFO_DEPTH, 4, console FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- memwrite  in  1  write strobe from the core.
- aluout  in  32  byte address from the core.
- writedata  in  32  write data from the core.
- readdata  out  32  read data, combinational from address and current state.
- cons_data  out  8  console byte at the FIFO head.
- cons_valid  out  1  FIFO non-empty.
- cons_ready  in  1  sink accepts the head byte.
- halt  out  1  sticky halt flag.
- halt_code  out  32  value written to HALT.

Behaviour:
- Reset (reset low, asynchronous): FIFO empty; cons_valid=0; cons_data=0; cycle=0; halt=0; halt_code=0; status=0. RAM contents are not reset.
- Decode:
  - MMIO when aluout[31:8]==MMIO_BASE[31:8]; otherwise RAM.
  - aluout[1:0] is ignored. All accesses are whole words.
  - RAM index is aluout[log2(DEPTH_WORDS)+1:2]; higher bits alias.
- Reads: zero-latency and combinational. A read in the same cycle as a write to that address returns the old value.
- Writes: take effect at the posedge of clk when memwrite=1.
- MMIO offset 0x00 CONSOLE:
  - Read returns {30'b0, full, empty}.
  - Write pushes writedata[7:0].
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle; count is then unchanged.
  - Otherwise the byte is dropped and status bit0 (overflow) is set.
- MMIO offset 0x04 CYCLE:
  - Read returns the counter.
  - Increments by 1 every cycle and wraps at 2^32. Freezes while halt=1.
  - A write loads writedata and takes precedence over the increment that cycle.
- MMIO offset 0x08 HALT:
  - Read returns halt_code.
  - First write sets halt=1 and halt_code=writedata.
  - Later writes are ignored. Only reset clears halt.
- MMIO offset 0x0C STATUS:
  - Read returns status (bit0 overflow, bit1 oor; other bits 0).
  - Write-1-to-clear per bit. If a set event and a clear hit the same bit in one cycle, set wins.
- Other MMIO offsets: read 0; writes ignored.
- FIFO:
  - Pop when cons_valid && cons_ready; cons_data is registered head data.
  - A byte pushed into an empty FIFO appears on cons_valid/cons_data the next cycle.
  - cons_data and cons_valid stay stable while cons_valid=1 and cons_ready=0.
  - Output order is write order.
- Reset asserted mid-operation flushes the FIFO immediately. RAM writes in flight that cycle are lost.

Optional Feature:
- Macro: DMEM_OOR_TRAP_EN.
- Defined: a RAM-region access with aluout >= DEPTH_WORDS*4 does not alias.
  - Reads return 32'hDEAD_BEEF.
  - Writes are dropped.
  - Either access sets status bit1 (oor) at the clock edge; for a read this happens whether or not memwrite is set.
- Undefined: addresses alias modulo DEPTH_WORDS and status bit1 reads 0.

Decomposition:
- Package dmem_pkg holds:
  - MMIO offset constants (OFF_CONSOLE, OFF_CYCLE, OFF_HALT, OFF_STATUS)
  - status bit indices (ST_OVERFLOW, ST_OOR)
  - the OOR_PATTERN constant
  - a typedef for the 2-bit console status
- One sub-module: console_fifo, a synchronous FIFO with push/full on one side and valid/ready/data on the other, parameterised by depth and width, with the same clk/reset.

Test Plan:
- RAM: write 32'h1234_5678 to 0x10, then read 0x10 → 32'h1234_5678.
  - Read 0x10 + DEPTH_WORDS*4 → same value without the macro; 32'hDEAD_BEEF and status=2 with the macro.
- Console: hold cons_ready=0 and push 'A','B','C','D','E' to MMIO_BASE → status bit0=1; CONSOLE read = 2'b10.
  - Then raise cons_ready → exactly 'A','B','C','D' drained in order, then cons_valid=0.
- Full FIFO with cons_ready=1: push 'Z' in the same cycle as a pop → accepted, overflow stays 0, 'Z' is output last.
- Cycle counter:
  - Release reset, wait 10 cycles → CYCLE reads 10.
  - Write 32'hFFFF_FFFE → reads FFFF_FFFE, FFFF_FFFF, then 0 on successive cycles.
- Halt: write 7 then 9 to HALT → halt=1, halt_code=7, CYCLE frozen. STATUS write 1 clears overflow.
- Async reset: assert reset mid-drain between clock edges → cons_valid=0 immediately; halt, halt_code and CYCLE are 0 after release.
